bcd_counter_n: RTL and testbench

Parametrised multi-digit BCD up/down counter. It is the next generation of the single-decade counter used in the lab designs.
- Adds: N digits, wrap or saturate mode, synchronous clear, cascade in/out, sticky overflow, and load-digit sanitising.
- Sits between front-panel controls and 7-seg display drivers.
- Can be chained through cnt_in/cnt_out to make wider counters.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_cell.sv | 40 ++++
 rtl/bcd_counter_n.sv | 110 +++++++++++
 tb/tb_bcd_counter_n.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Clamp an arbitrary nibble into the legal BCD range.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    if (d > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: next value and carry/borrow out for a single digit.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       en_in,
  output logic [3:0] next_digit,
  output logic       en_out
);

  // Increment or decrement when enabled; en_out marks the wrap of this digit.
  always_comb begin
    next_digit = digit;
    en_out     = 1'b0;
    if (en_in) begin
      if (up) begin
        if (digit == BCD_MAX) begin
          next_digit = BCD_MIN;
          en_out     = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
          en_out     = 1'b0;
        end
      end else begin
        if (digit == BCD_MIN) begin
          next_digit = BCD_MAX;
          en_out     = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
          en_out     = 1'b0;
        end
      end
    end else begin
      next_digit = digit;
      en_out     = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with wrap/saturate, cascade, sticky overflow
// and sanitised parallel load.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 32'd2,
  parameter int unsigned SATURATE = 32'd0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  counter_on,
  input  logic                  counter_up,
  input  logic                  cnt_in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  cnt_out,
  output logic                  ovf,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] count_r;
  logic                tc_r;
  logic                ovf_r;
  logic                load_err_r;

  logic [4*DIGITS-1:0] next_s;
  logic [4*DIGITS-1:0] step_val_s;
  logic [4*DIGITS-1:0] load_val_s;
  logic                load_bad_s;
  logic [DIGITS:0]     carry_s;
  logic                at_term_s;
  logic                step_s;

  // The ripple carry out of the top digit is set exactly when every digit
  // sits at the terminal value for the current direction.
  assign carry_s[0] = 1'b1;
  assign at_term_s  = carry_s[DIGITS];
  assign step_s     = counter_on & cnt_in;
  assign cnt_out    = counter_on & cnt_in & at_term_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit      (count_r[4*g +: 4]),
      .up         (counter_up),
      .en_in      (carry_s[g]),
      .next_digit (next_s[4*g +: 4]),
      .en_out     (carry_s[g+1])
    );
  end

  // Saturating builds hold the terminal value instead of wrapping.
  always_comb begin
    step_val_s = next_s;
    if ((SATURATE != 32'd0) && at_term_s) begin
      step_val_s = count_r;
    end else begin
      step_val_s = next_s;
    end
  end

  // Clamp each loaded digit and flag any that were out of range.
  always_comb begin
    load_val_s = {(4*DIGITS){1'b0}};
    load_bad_s = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_val_s[4*i +: 4] = bcd_sanitize(data_in[4*i +: 4]);
      if (data_in[4*i +: 4] > BCD_MAX) begin
        load_bad_s = 1'b1;
      end else begin
        load_bad_s = load_bad_s;
      end
    end
  end

  // Count register and status flags, priority clr > load > step > hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r    <= {(4*DIGITS){1'b0}};
      tc_r       <= 1'b0;
      ovf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else if (clr) begin
      count_r    <= {(4*DIGITS){1'b0}};
      tc_r       <= 1'b0;
      ovf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else if (load) begin
      count_r    <= load_val_s;
      tc_r       <= 1'b0;
      load_err_r <= load_bad_s;
    end else if (step_s) begin
      count_r    <= step_val_s;
      tc_r       <= at_term_s;
      ovf_r      <= ovf_r | at_term_s;
      load_err_r <= 1'b0;
    end else begin
      tc_r       <= 1'b0;
      load_err_r <= 1'b0;
    end
  end

  assign count    = count_r;
  assign tc       = tc_r;
  assign ovf      = ovf_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: wrapping and saturating 2-digit counters plus a cascaded
// pair of 1-digit counters, all sharing the same control stimulus.
module tb_bcd_counter_n;

  logic       clk;
  logic       resetn;
  logic       clr;
  logic       load;
  logic [7:0] data_in;
  logic       counter_on;
  logic       counter_up;

  logic [7:0] count_wr, count_sat;
  logic       tc_wr, tc_sat, cnt_out_wr, cnt_out_sat;
  logic       ovf_wr, ovf_sat, load_err_wr, load_err_sat;
  logic [3:0] count_lo, count_hi;
  logic       tc_lo, tc_hi, cnt_out_lo, cnt_out_hi;
  logic       ovf_lo, ovf_hi, load_err_lo, load_err_hi;

  int checks;
  int failures;

  bcd_counter_n #(.DIGITS(32'd2), .SATURATE(32'd0)) dut_wr (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .data_in(data_in),
    .counter_on(counter_on), .counter_up(counter_up), .cnt_in(1'b1),
    .count(count_wr), .tc(tc_wr), .cnt_out(cnt_out_wr), .ovf(ovf_wr),
    .load_err(load_err_wr));

  bcd_counter_n #(.DIGITS(32'd2), .SATURATE(32'd1)) dut_sat (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .data_in(data_in),
    .counter_on(counter_on), .counter_up(counter_up), .cnt_in(1'b1),
    .count(count_sat), .tc(tc_sat), .cnt_out(cnt_out_sat), .ovf(ovf_sat),
    .load_err(load_err_sat));

  bcd_counter_n #(.DIGITS(32'd1), .SATURATE(32'd0)) dut_lo (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .data_in(data_in[3:0]),
    .counter_on(counter_on), .counter_up(counter_up), .cnt_in(1'b1),
    .count(count_lo), .tc(tc_lo), .cnt_out(cnt_out_lo), .ovf(ovf_lo),
    .load_err(load_err_lo));

  bcd_counter_n #(.DIGITS(32'd1), .SATURATE(32'd0)) dut_hi (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .data_in(data_in[3:0]),
    .counter_on(counter_on), .counter_up(counter_up), .cnt_in(cnt_out_lo),
    .count(count_hi), .tc(tc_hi), .cnt_out(cnt_out_hi), .ovf(ovf_hi),
    .load_err(load_err_hi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; data_in = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; clr = 1'b0; load = 1'b0; data_in = 8'h00;
    counter_on = 1'b0; counter_up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count_wr !== 8'h00 || tc_wr !== 1'b0 || ovf_wr !== 1'b0 || load_err_wr !== 1'b0) begin failures++; $display("FAIL reset_wr count=%h tc=%b ovf=%b lerr=%b want 00/0/0/0", count_wr, tc_wr, ovf_wr, load_err_wr); end
    @(negedge clk); resetn = 1'b1;
    tick();
    checks++; if (count_sat !== 8'h00 || tc_sat !== 1'b0 || ovf_sat !== 1'b0) begin failures++; $display("FAIL reset_sat count=%h tc=%b ovf=%b want 00/0/0", count_sat, tc_sat, ovf_sat); end
  endtask

  task automatic test_async_reset();
    counter_up = 1'b1;
    do_load(8'h99);
    counter_on = 1'b1; tick(); counter_on = 1'b0;
    do_load(8'h36);
    counter_on = 1'b1; tick(); counter_on = 1'b0;
    checks++; if (count_wr !== 8'h37 || ovf_wr !== 1'b1) begin failures++; $display("FAIL count_to_37 count=%h ovf=%b want 37/1", count_wr, ovf_wr); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (count_wr !== 8'h00 || tc_wr !== 1'b0 || ovf_wr !== 1'b0) begin failures++; $display("FAIL async_reset count=%h tc=%b ovf=%b want 00/0/0", count_wr, tc_wr, ovf_wr); end
    @(negedge clk); resetn = 1'b1;
    tick();
  endtask

  task automatic test_up_wrap();
    counter_up = 1'b1;
    do_load(8'h98);
    checks++; if (count_wr !== 8'h98 || tc_wr !== 1'b0 || ovf_wr !== 1'b0) begin failures++; $display("FAIL load_98 count=%h tc=%b ovf=%b want 98/0/0", count_wr, tc_wr, ovf_wr); end
    counter_on = 1'b1; tick();
    checks++; if (count_wr !== 8'h99 || tc_wr !== 1'b0 || cnt_out_wr !== 1'b1) begin failures++; $display("FAIL up_99 count=%h tc=%b cnt_out=%b want 99/0/1", count_wr, tc_wr, cnt_out_wr); end
    tick();
    checks++; if (count_wr !== 8'h00 || tc_wr !== 1'b1 || ovf_wr !== 1'b1 || cnt_out_wr !== 1'b0) begin failures++; $display("FAIL up_wrap count=%h tc=%b ovf=%b cnt_out=%b want 00/1/1/0", count_wr, tc_wr, ovf_wr, cnt_out_wr); end
    checks++; if (count_sat !== 8'h99 || tc_sat !== 1'b1 || ovf_sat !== 1'b1) begin failures++; $display("FAIL up_sat count=%h tc=%b ovf=%b want 99/1/1", count_sat, tc_sat, ovf_sat); end
    counter_on = 1'b0; tick();
    checks++; if (count_wr !== 8'h00 || tc_wr !== 1'b0 || ovf_wr !== 1'b1) begin failures++; $display("FAIL hold_after_wrap count=%h tc=%b ovf=%b want 00/0/1", count_wr, tc_wr, ovf_wr); end
  endtask

  task automatic test_down_saturate();
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (ovf_sat !== 1'b0 || count_sat !== 8'h00) begin failures++; $display("FAIL clr_sat count=%h ovf=%b want 00/0", count_sat, ovf_sat); end
    counter_up = 1'b0;
    do_load(8'h01);
    counter_on = 1'b1; tick();
    checks++; if (count_sat !== 8'h00 || tc_sat !== 1'b0 || ovf_sat !== 1'b0) begin failures++; $display("FAIL down1_sat count=%h tc=%b ovf=%b want 00/0/0", count_sat, tc_sat, ovf_sat); end
    tick();
    checks++; if (count_sat !== 8'h00 || tc_sat !== 1'b1 || ovf_sat !== 1'b1) begin failures++; $display("FAIL down2_sat count=%h tc=%b ovf=%b want 00/1/1", count_sat, tc_sat, ovf_sat); end
    checks++; if (count_wr !== 8'h99 || tc_wr !== 1'b1) begin failures++; $display("FAIL down2_wr count=%h tc=%b want 99/1", count_wr, tc_wr); end
    tick();
    checks++; if (count_sat !== 8'h00 || tc_sat !== 1'b1 || cnt_out_sat !== 1'b1) begin failures++; $display("FAIL down3_sat count=%h tc=%b cnt_out=%b want 00/1/1", count_sat, tc_sat, cnt_out_sat); end
    checks++; if (count_wr !== 8'h98 || tc_wr !== 1'b0 || ovf_wr !== 1'b1) begin failures++; $display("FAIL down3_wr count=%h tc=%b ovf=%b want 98/0/1", count_wr, tc_wr, ovf_wr); end
    counter_on = 1'b0; counter_up = 1'b1;
  endtask

  task automatic test_load_sanitize();
    do_load(8'hA5);
    checks++; if (count_wr !== 8'h95 || load_err_wr !== 1'b1) begin failures++; $display("FAIL load_A5 count=%h lerr=%b want 95/1", count_wr, load_err_wr); end
    tick();
    checks++; if (count_wr !== 8'h95 || load_err_wr !== 1'b0) begin failures++; $display("FAIL load_err_pulse count=%h lerr=%b want 95/0", count_wr, load_err_wr); end
    do_load(8'h42);
    checks++; if (count_wr !== 8'h42 || load_err_wr !== 1'b0) begin failures++; $display("FAIL load_42 count=%h lerr=%b want 42/0", count_wr, load_err_wr); end
    do_load(8'h3F);
    checks++; if (count_wr !== 8'h39 || load_err_wr !== 1'b1) begin failures++; $display("FAIL load_3F count=%h lerr=%b want 39/1", count_wr, load_err_wr); end
  endtask

  task automatic test_priority();
    counter_up = 1'b1;
    clr = 1'b1; load = 1'b1; data_in = 8'h55; counter_on = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (count_wr !== 8'h00 || ovf_wr !== 1'b0 || tc_wr !== 1'b0) begin failures++; $display("FAIL clr_wins count=%h ovf=%b tc=%b want 00/0/0", count_wr, ovf_wr, tc_wr); end
    data_in = 8'h99; tick();
    checks++; if (count_wr !== 8'h99 || tc_wr !== 1'b0) begin failures++; $display("FAIL load_step_99 count=%h tc=%b want 99/0", count_wr, tc_wr); end
    data_in = 8'h55; tick();
    checks++; if (count_wr !== 8'h55 || tc_wr !== 1'b0 || ovf_wr !== 1'b0) begin failures++; $display("FAIL load_beats_term count=%h tc=%b ovf=%b want 55/0/0", count_wr, tc_wr, ovf_wr); end
    load = 1'b0; counter_on = 1'b0;
  endtask

  task automatic test_cascade();
    logic [7:0] exp_v;
    logic [7:0] got_v;
    clr = 1'b1; tick(); clr = 1'b0;
    counter_up = 1'b1; counter_on = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      exp_v = 8'(((i / 10) << 4) | (i % 10));
      got_v = {count_hi, count_lo};
      checks++; if (got_v !== exp_v) begin failures++; $display("FAIL cascade_step%0d got=%h want=%h", i, got_v, exp_v); end
    end
    counter_on = 1'b0; tick();
    got_v = {count_hi, count_lo};
    checks++; if (got_v !== 8'h25 || tc_hi !== 1'b0) begin failures++; $display("FAIL cascade_final got=%h tc_hi=%b want 25/0", got_v, tc_hi); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_async_reset();
    test_up_wrap();
    test_down_saturate();
    test_load_sanitize();
    test_priority();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
